sobel_edge: RTL and testbench
=============================

# sobel_edge

Streaming 3×3 Sobel edge detector between the UART byte receiver and the VGA picture buffer. Accepts a 100×100 8-bit grayscale image in raster order, one pixel per `pi_flag` strobe. Emits a 98×98 binary edge image (0xFF edge / 0x00 background) as `po_data`/`po_flag`, in raster order, one strobe per output pixel. The display stage writes these to consecutive RAM addresses 0..9603.

## Interface
- `IMG_W`, 100, input image width in pixels
- `IMG_H`, 100, input image height in pixels
- `THRESHOLD`, 11'd100, edge threshold; edge when |Gx|+|Gy| ≥ THRESHOLD
- `EDGE_VAL`, 8'hFF, `po_data` value for an edge pixel
- `BG_VAL`, 8'h00, `po_data` value for a non-edge pixel

Ports:
- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  reset; asynchronous, active-low
- `pi_data`  in  8  grayscale pixel; valid when `pi_flag`=1
- `pi_flag`  in  1  single-cycle pixel strobe; may be high on consecutive cycles
- `po_data`  out  8  edge pixel (EDGE_VAL/BG_VAL)
- `po_flag`  out  1  single-cycle output strobe
- `po_frame_end`  out  1  high with `po_flag` for the last (98×98th) output of a frame

## Operation
- Counters: `col` 0..IMG_W-1 and `row` 0..IMG_H-1 advance on each accepted pixel.
  - `col` wraps to 0 at IMG_W-1, and `row` increments at that point.
  - At (IMG_H-1, IMG_W-1) both counters wrap to 0. The next pixel starts a new frame.
  - There is no frame sync input. Framing is by count only.
- Line buffers `lb0` (row-2) and `lb1` (row-1), each IMG_W×8.
  - On an accepted pixel, read `lb0[col]` and `lb1[col]` with read-old-data semantics.
  - Then write `lb0[col]` ← old `lb1[col]`, and `lb1[col]` ← `pi_data`.
- 3×3 window registers shift left on each accepted pixel. The new right column is {`lb0[col]`, `lb1[col]`, `pi_data`} (top, mid, bottom).
- The window is held when `pi_flag`=0.
- The window is not cleared at row start. Outputs are suppressed for col<2 anyway.
- Tag `v0` = `pi_flag` && row≥2 && col≥2, using pre-increment counters. Only tagged pixels produce output.
- Window indices: p[r][c], r = 0 top, c = 0 left.
  - Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Both are signed 11-bit, range ±1020.
- mag = |Gx| + |Gy|, unsigned 11-bit, range 0..2040. No saturation is needed.
- `po_data` = EDGE_VAL if mag ≥ THRESHOLD, else BG_VAL.
- `po_frame_end` is tagged at the pixel with row = IMG_H-1, col = IMG_W-1 and travels with `v0`.
- Output count per frame is exactly (IMG_W-2)·(IMG_H-2) = 9604.
- Output k corresponds to the input window centred at (k/98 + 1, k%98 + 1).

## Timing
- Pipeline stages:
  - E0: counters, line buffers and window update; `v0` registered.
  - E1: Gx and Gy registered.
  - E2: mag registered.
  - E3: `po_data`, `po_flag` and `po_frame_end` registered.
- Latency: `pi_flag` high in cycle k → `po_flag` high in cycle k+4. This is fixed and independent of input spacing.
- The pipeline runs every cycle, so no bubbles arise. Back-to-back inputs give back-to-back outputs.
- `po_data` holds its last value when `po_flag`=0. Downstream must sample only on `po_flag`.
- Reset values: `po_data` = 8'h00, `po_flag` = 0, `po_frame_end` = 0, counters = 0, all valid tags = 0.
- Line-buffer and window contents are don't-care after reset.
- Reset mid-frame: all outputs drop on reset assertion. In-flight results are discarded. After release, the next pixel is (0,0) of a new frame.
- Reset release with `pi_flag`=1 in the first cycle: that pixel is accepted as (0,0).

## Test plan
- Uniform frame, all pixels 0x80, back-to-back → exactly 9604 `po_flag` pulses, all `po_data` = 0x00. One `po_frame_end`, on pulse 9604.
- Vertical step: cols 0..49 = 0x00, cols 50..99 = 0xFF → each output row has outputs 48 and 49 = 0xFF (|Gx| = 1020). The other 96 outputs in the row are 0x00.
- Threshold boundary with THRESHOLD = 100:
  - Rows 0..49 = 0, rows 50..99 = 25 (Gy = 100) → output rows 48 and 49 are all 0xFF.
  - Repeat with 24 (Gy = 96) → all outputs 0x00.
- Latency and spacing: inputs with `pi_flag` every 3rd cycle, then with random gaps → every `po_flag` occurs exactly 4 cycles after its tagged `pi_flag`. The first `po_flag` occurs 4 cycles after input pixel 202, i.e. (2,2).
- Frame wrap: two consecutive frames of the step image with no gap → the second frame output is bit-identical to the first. `po_frame_end` pulses exactly twice.
- Reset mid-frame: assert `sys_rst_n`=0 for 2 cycles after 5000 pixels → `po_flag` = 0 within the same cycle. A following full frame yields exactly 9604 outputs with correct values.

Source files
------------

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: 100x100 grayscale raster in, 98x98 binary edge map out.
// Four-stage pipeline (window / gradients / magnitude / threshold) with fixed 4-cycle latency.
module sobel_edge #(
   parameter int          IMG_W     = 100,
   parameter int          IMG_H     = 100,
   parameter logic [10:0] THRESHOLD = 11'd100,
   parameter logic [7:0]  EDGE_VAL  = 8'hFF,
   parameter logic [7:0]  BG_VAL    = 8'h00
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic [7:0] po_data,
   output logic       po_flag,
   output logic       po_frame_end
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_reg;
   logic [RW-1:0] row_reg;
   logic          col_last;
   logic          row_last;

   logic [7:0] lb0 [0:IMG_W-1];
   logic [7:0] lb1 [0:IMG_W-1];
   logic [7:0] lb0_rd;
   logic [7:0] lb1_rd;
   logic [7:0] new_col [0:2];
   logic [7:0] p [0:2][0:2];

   logic              v0_reg, fe0_reg;
   logic              v1_reg, fe1_reg;
   logic              v2_reg, fe2_reg;
   logic [10:0]       gx_reg, gy_reg;
   logic [10:0]       mag_reg;
   logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic [10:0]       abs_gx, abs_gy;

   assign col_last = (col_reg == CW'(IMG_W - 1));
   assign row_last = (row_reg == RW'(IMG_H - 1));

   // Read before write in the same cycle gives the old line contents to the window.
   assign lb0_rd     = lb0[col_reg];
   assign lb1_rd     = lb1[col_reg];
   assign new_col[0] = lb0_rd;
   assign new_col[1] = lb1_rd;
   assign new_col[2] = pi_data;

   // E0: position counters and valid/frame-end tags
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         col_reg <= '0;
         row_reg <= '0;
         v0_reg  <= 1'b0;
         fe0_reg <= 1'b0;
      end else begin
         v0_reg  <= pi_flag && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
         fe0_reg <= pi_flag && row_last && col_last;
         if (pi_flag) begin
            if (col_last) begin
               col_reg <= '0;
               row_reg <= row_last ? '0 : row_reg + RW'(1);
            end else begin
               col_reg <= col_reg + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (pi_flag) begin
         lb0[col_reg] <= lb1_rd;
         lb1[col_reg] <= pi_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         logic [7:0] w0_reg, w1_reg, w2_reg;
         always_ff @(posedge sys_clk) begin
            if (pi_flag) begin
               w0_reg <= w1_reg;
               w1_reg <= w2_reg;
               w2_reg <= new_col[gi];
            end
         end
         assign p[gi][0] = w0_reg;
         assign p[gi][1] = w1_reg;
         assign p[gi][2] = w2_reg;
      end
   endgenerate

   always_comb begin
      gx_pos = {2'b00, p[0][2]} + {1'b0, p[1][2], 1'b0} + {2'b00, p[2][2]};
      gx_neg = {2'b00, p[0][0]} + {1'b0, p[1][0], 1'b0} + {2'b00, p[2][0]};
      gy_pos = {2'b00, p[2][0]} + {1'b0, p[2][1], 1'b0} + {2'b00, p[2][2]};
      gy_neg = {2'b00, p[0][0]} + {1'b0, p[0][1], 1'b0} + {2'b00, p[0][2]};
   end

   // Gradients are two's complement; magnitude never exceeds 2040 so 11 bits suffice.
   assign abs_gx = gx_reg[10] ? (~gx_reg + 11'd1) : gx_reg;
   assign abs_gy = gy_reg[10] ? (~gy_reg + 11'd1) : gy_reg;

   // E1..E3
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v1_reg       <= 1'b0;
         fe1_reg      <= 1'b0;
         gx_reg       <= '0;
         gy_reg       <= '0;
         v2_reg       <= 1'b0;
         fe2_reg      <= 1'b0;
         mag_reg      <= '0;
         po_flag      <= 1'b0;
         po_frame_end <= 1'b0;
         po_data      <= 8'h00;
      end else begin
         v1_reg       <= v0_reg;
         fe1_reg      <= fe0_reg;
         gx_reg       <= {1'b0, gx_pos} - {1'b0, gx_neg};
         gy_reg       <= {1'b0, gy_pos} - {1'b0, gy_neg};
         v2_reg       <= v1_reg;
         fe2_reg      <= fe1_reg;
         mag_reg      <= abs_gx + abs_gy;
         po_flag      <= v2_reg;
         po_frame_end <= fe2_reg;
         if (v2_reg) begin
            po_data <= (mag_reg >= THRESHOLD) ? EDGE_VAL : BG_VAL;
         end
      end
   end

endmodule

// File: tb/tb_sobel_edge.sv
module tb_sobel_edge;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [7:0] pi_data = 8'h00;
   logic       pi_flag = 1'b0;
   logic [7:0] po_data;
   logic       po_flag;
   logic       po_frame_end;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       fe;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t drv_e;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_out    = 0;
   int n_fe     = 0;
   int first_out_cyc = 0;
   int c202     = 0;
   int row      = 0;
   int col      = 0;
   int k        = 0;

   sobel_edge dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .pi_data      (pi_data),
      .pi_flag      (pi_flag),
      .po_data      (po_data),
      .po_flag      (po_flag),
      .po_frame_end (po_frame_end)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   initial begin
      #5ms;
      $error("FAIL timeout: simulation did not complete within wait limit");
      $finish;
   end

   function automatic logic [7:0] pix(input int pat, input int r, input int c);
      case (pat)
         0:       return 8'h80;
         1:       return (c >= 50) ? 8'hFF : 8'h00;
         2:       return (r >= 50) ? 8'd25 : 8'h00;
         default: return (r >= 50) ? 8'd24 : 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] exp_val(input int pat, input int kk);
      int rr, cc;
      rr = kk / 98;
      cc = kk % 98;
      case (pat)
         1:       return (cc == 48 || cc == 49) ? 8'hFF : 8'h00;
         2:       return (rr == 48 || rr == 49) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic send(input int pat, input int gap);
      for (int i = 0; i < gap; i++) begin
         @(negedge sys_clk);
         pi_flag = 1'b0;
      end
      @(negedge sys_clk);
      pi_flag = 1'b1;
      pi_data = pix(pat, row, col);
      if (row == 2 && col == 2) c202 = cyc;
      if (row >= 2 && col >= 2) begin
         drv_e.cyc = cyc;
         drv_e.d   = exp_val(pat, k);
         drv_e.fe  = (row == 99 && col == 99);
         exp_q.push_back(drv_e);
         k++;
      end
      if (col == 99) begin
         col = 0;
         if (row == 99) begin
            row = 0;
            k   = 0;
         end else begin
            row++;
         end
      end else begin
         col++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         pi_flag = 1'b0;
      end
   endtask

   task automatic check_done(input string name, input int eo, input int ef);
      idle(8);
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_outputs"}, n_out, eo);
      chk({name, "_frame_ends"}, n_fe, ef);
      $display("%s: outputs=%0d frame_ends=%0d", name, n_out, n_fe);
      n_out = 0;
      n_fe  = 0;
   endtask

   always @(negedge sys_clk) begin
      if (po_flag) begin
         n_out++;
         if (n_out == 1) first_out_cyc = cyc;
         if (po_frame_end) n_fe++;
         if (exp_q.size() == 0) begin
            chk("unexpected_output", po_flag, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("latency", cyc, mon_e.cyc + 4);
            chk("po_data", po_data, mon_e.d);
            chk("po_frame_end", po_frame_end, mon_e.fe);
         end
      end else if (po_frame_end) begin
         chk("stray_frame_end", po_frame_end, 1'b0);
      end
   end

   initial begin
      sys_rst_n = 1'b0;
      idle(3);
      chk("reset_po_flag", po_flag, 1'b0);
      chk("reset_po_data", po_data, 8'h00);
      chk("reset_po_frame_end", po_frame_end, 1'b0);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;

      for (int i = 0; i < 10000; i++) send(0, 0);
      check_done("uniform", 9604, 1);

      for (int i = 0; i < 20000; i++) send(1, 0);
      check_done("step_two_frames", 19208, 2);

      for (int i = 0; i < 10000; i++) send(2, 0);
      check_done("threshold_100", 9604, 1);

      for (int i = 0; i < 10000; i++) send(3, 0);
      check_done("threshold_96", 9604, 0 + 1);

      for (int i = 0; i < 600; i++) send(1, 2);
      for (int i = 0; i < 4400; i++) send(1, int'($urandom_range(0, 3)));
      chk("first_output_cycle", first_out_cyc, c202 + 4);
      $display("spacing: first output cycle=%0d pixel202 cycle=%0d", first_out_cyc, c202);
      @(posedge sys_clk);
      #2;
      pi_flag   = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      chk("midreset_po_flag", po_flag, 1'b0);
      chk("midreset_po_data", po_data, 8'h00);
      chk("midreset_po_frame_end", po_frame_end, 1'b0);
      exp_q.delete();
      row   = 0;
      col   = 0;
      k     = 0;
      n_out = 0;
      n_fe  = 0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;

      for (int i = 0; i < 10000; i++) send(1, 0);
      check_done("after_reset", 9604, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
